// File: rtl/pkt_capture_if.sv
// Avalon-ST ingress stream from the MAC into the capture stage.
interface pkt_capture_if;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned EMPTY_W = 2;

  logic [DATA_W-1:0]  st_data;
  logic               st_valid;
  logic               st_ready;
  logic               st_sop;
  logic               st_eop;
  logic [EMPTY_W-1:0] st_empty;

  modport master (output st_data, st_valid, st_sop, st_eop, st_empty, input st_ready);
  modport slave  (input st_data, st_valid, st_sop, st_eop, st_empty, output st_ready);
endinterface

// File: rtl/pkt_capture.sv
// Frame ingress: snap-length truncation into the packet FIFO, arrival timestamp,
// and one-frame-in-flight handoff to the buffer write controller.
module pkt_capture #(
  parameter int unsigned FIFO_DEPTH = 512,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   snaplen,
  pkt_capture_if.slave                  st,
  output logic                          fifo_wr,
  output logic [31:0]                   fifo_in,
  input  logic                          fifo_full,
  input  logic [$clog2(FIFO_DEPTH)-1:0] usedw,
  input  logic [31:0]                   seconds,
  input  logic [31:0]                   nanoseconds,
  output logic [31:0]                   ts_seconds,
  output logic [31:0]                   ts_nanoseconds,
  output logic                          wr_ctrl,
  output logic [31:0]                   pkt_begin,
  output logic [31:0]                   pkt_end,
  input  logic                          wr_ctrl_rdy,
  output logic [CNT_W-1:0]              pkt_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          proto_err
);
  localparam int unsigned USEDW_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned WORDS_W  = USEDW_W + 1;
  localparam int unsigned BYTES_W  = 17;
  localparam int unsigned SUM_W    = BYTES_W + 1;
  localparam int unsigned MAX_SNAP = FIFO_DEPTH * 4;

  typedef enum logic [2:0] {IDLE, CAPTURE, DROP, HANDOFF, WAIT_DONE} state_t;

  state_t             state;
  logic               ready_en;
  logic [BYTES_W-1:0] byte_cnt;
  logic [BYTES_W-1:0] eff_snap;

  logic [BYTES_W-1:0] snap_in;
  logic [BYTES_W-1:0] cap_base;
  logic [BYTES_W-1:0] cap_snap;
  logic [SUM_W-1:0]   cnt_sum;
  logic [BYTES_W-1:0] cnt_next;
  logic [BYTES_W-1:0] len_next;
  logic [BYTES_W-1:0] len_partial;
  logic [2:0]         beat_bytes;
  logic [WORDS_W-1:0] need_words;
  logic [WORDS_W-1:0] free_words;
  logic               st_ready_c;
  logic               accept;
  logic               sop_start;
  logic               no_room;
  logic               cap_beat;
  logic               sop_abort;
  logic               wr_en;

  // Snap length for a frame starting now; zero or oversize means the whole FIFO.
  always_comb begin
    snap_in = BYTES_W'(snaplen);
    if (snaplen == 16'd0 || BYTES_W'(snaplen) > BYTES_W'(MAX_SNAP))
      snap_in = BYTES_W'(MAX_SNAP);
  end

  assign need_words = WORDS_W'((snap_in + BYTES_W'(3)) >> 2);
  assign free_words = fifo_full ? '0 : WORDS_W'(FIFO_DEPTH) - WORDS_W'(usedw);
  assign no_room    = free_words < need_words;

  // A pending sop in CAPTURE is held off so it can be re-presented as a new frame.
  always_comb begin
    st_ready_c = 1'b0;
    if (ready_en) begin
      case (state)
        IDLE, DROP: st_ready_c = 1'b1;
        CAPTURE:    st_ready_c = !(st.st_sop || fifo_full);
        default:    st_ready_c = 1'b0;
      endcase
    end
  end
  assign st.st_ready = st_ready_c;

  assign accept    = st.st_valid && st_ready_c;
  assign sop_start = (state == IDLE) && accept && st.st_sop && enable;
  assign cap_beat  = (sop_start && !no_room) || ((state == CAPTURE) && accept);
  assign sop_abort = (state == CAPTURE) && st.st_valid && st.st_sop;

  // The first beat of a frame counts from zero against the freshly sampled snap length.
  assign cap_base    = (state == CAPTURE) ? byte_cnt : '0;
  assign cap_snap    = (state == CAPTURE) ? eff_snap : snap_in;
  assign beat_bytes  = st.st_eop ? 3'd4 - 3'(st.st_empty) : 3'd4;
  assign cnt_sum     = SUM_W'(cap_base) + SUM_W'(beat_bytes);
  assign cnt_next    = cnt_sum[BYTES_W] ? '1 : cnt_sum[BYTES_W-1:0];
  assign len_next    = (cnt_next < cap_snap) ? cnt_next : cap_snap;
  assign len_partial = (byte_cnt < eff_snap) ? byte_cnt : eff_snap;
  assign wr_en       = cap_base < cap_snap;

  assign pkt_begin = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ready_en       <= 1'b0;
      byte_cnt       <= '0;
      eff_snap       <= '0;
      fifo_wr        <= 1'b0;
      fifo_in        <= '0;
      ts_seconds     <= '0;
      ts_nanoseconds <= '0;
      wr_ctrl        <= 1'b0;
      pkt_end        <= '0;
      pkt_count      <= '0;
      drop_count     <= '0;
      proto_err      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      fifo_wr  <= 1'b0;
      wr_ctrl  <= 1'b0;

      if (sop_start) begin
        ts_seconds     <= seconds;
        ts_nanoseconds <= nanoseconds;
        eff_snap       <= snap_in;
      end

      if (cap_beat) begin
        fifo_wr  <= wr_en;
        if (wr_en) fifo_in <= st.st_data;
        byte_cnt <= cnt_next;
        if (st.st_eop) begin
          pkt_end <= 32'(len_next);
          wr_ctrl <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (sop_start) begin
            if (no_room) begin
              if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
              if (!st.st_eop) state <= DROP;
            end else begin
              state <= st.st_eop ? HANDOFF : CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sop_abort) begin
            proto_err <= 1'b1;
            pkt_end   <= 32'(len_partial);
            wr_ctrl   <= 1'b1;
            state     <= HANDOFF;
          end else if (accept && st.st_eop) begin
            state <= HANDOFF;
          end
        end
        DROP: begin
          if (accept && st.st_eop) state <= IDLE;
        end
        HANDOFF: begin
          if (pkt_count != '1) pkt_count <= pkt_count + CNT_W'(1);
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (wr_ctrl_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_capture.sv
// Directed bench for pkt_capture: full, partial, truncated, dropped, aborted and
// back-to-back frames plus reset behaviour.
`timescale 1ns/1ps
module tb_pkt_capture;
  localparam int unsigned FIFO_DEPTH = 512;
  localparam int unsigned CNT_W      = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [15:0]       snaplen = 16'd0;
  logic              fifo_wr;
  logic [31:0]       fifo_in;
  logic              fifo_full = 1'b0;
  logic [8:0]        usedw = 9'd0;
  logic [31:0]       seconds = 32'd0;
  logic [31:0]       nanoseconds = 32'd0;
  logic [31:0]       ts_seconds;
  logic [31:0]       ts_nanoseconds;
  logic              wr_ctrl;
  logic [31:0]       pkt_begin;
  logic [31:0]       pkt_end;
  logic              wr_ctrl_rdy = 1'b0;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  drop_count;
  logic              proto_err;

  pkt_capture_if bus ();

  pkt_capture #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .snaplen(snaplen), .st(bus),
    .fifo_wr(fifo_wr), .fifo_in(fifo_in), .fifo_full(fifo_full), .usedw(usedw),
    .seconds(seconds), .nanoseconds(nanoseconds), .ts_seconds(ts_seconds),
    .ts_nanoseconds(ts_nanoseconds), .wr_ctrl(wr_ctrl), .pkt_begin(pkt_begin),
    .pkt_end(pkt_end), .wr_ctrl_rdy(wr_ctrl_rdy), .pkt_count(pkt_count),
    .drop_count(drop_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int ctrl_cnt = 0;
  bit stall_seen = 1'b0;
  logic [31:0] wr_log [0:1023];

  // Log every FIFO write and handoff pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_wr === 1'b1) begin
      if (wr_cnt < 1024) wr_log[wr_cnt] = fifo_in;
      wr_cnt++;
    end
    if (wr_ctrl === 1'b1) ctrl_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                           input logic [1:0] emp);
    int n;
    n = 0;
    bus.st_data = d; bus.st_sop = sop; bus.st_eop = eop; bus.st_empty = emp;
    bus.st_valid = 1'b1;
    @(negedge clk);
    while (bus.st_ready !== 1'b1 && n < 100) begin
      n++; stall_seen = 1'b1; @(negedge clk);
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout: data %h not accepted within 100 cycles", d);
    end
    @(posedge clk); #1;
    bus.st_valid = 1'b0; bus.st_sop = 1'b0; bus.st_eop = 1'b0; bus.st_empty = 2'd0;
  endtask

  task automatic send_frame(input int beats, input logic [1:0] emp, input logic [31:0] base);
    for (int i = 0; i < beats; i++) begin
      send_beat(base + 32'(i), i == 0, i == beats - 1, (i == beats - 1) ? emp : 2'd0);
      seconds = seconds + 32'd1;
      nanoseconds = nanoseconds + 32'd10;
    end
  endtask

  task automatic finish_frame;
    @(posedge clk); #1; wr_ctrl_rdy = 1'b1;
    @(posedge clk); #1; wr_ctrl_rdy = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL rst_st_ready got %b exp 0", bus.st_ready); end
    checks++; if (fifo_wr !== 1'b0) begin errors++; $display("FAIL rst_fifo_wr got %b exp 0", fifo_wr); end
    checks++; if (fifo_in !== 32'd0) begin errors++; $display("FAIL rst_fifo_in got %h exp 0", fifo_in); end
    checks++; if (wr_ctrl !== 1'b0) begin errors++; $display("FAIL rst_wr_ctrl got %b exp 0", wr_ctrl); end
    checks++; if (pkt_begin !== 32'd0) begin errors++; $display("FAIL rst_pkt_begin got %h exp 0", pkt_begin); end
    checks++; if (pkt_end !== 32'd0) begin errors++; $display("FAIL rst_pkt_end got %h exp 0", pkt_end); end
    checks++; if (ts_seconds !== 32'd0 || ts_nanoseconds !== 32'd0) begin errors++; $display("FAIL rst_ts got %h/%h exp 0/0", ts_seconds, ts_nanoseconds); end
    checks++; if (pkt_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", pkt_count, drop_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got %b exp 0", proto_err); end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready_early got %b exp 0", bus.st_ready); end
    @(posedge clk); #1;
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", bus.st_ready); end
  endtask

  task automatic test_full_frame;
    logic [31:0] es, ens;
    int wb, cb;
    snaplen = 16'd0; enable = 1'b1;
    seconds = 32'h0000_1000; nanoseconds = 32'd500;
    es = seconds; ens = nanoseconds; wb = wr_cnt; cb = ctrl_cnt;
    send_frame(16, 2'd0, 32'hA000_0000);
    checks++; if (wr_ctrl !== 1'b1) begin errors++; $display("FAIL full_wr_ctrl got %b exp 1", wr_ctrl); end
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_ready_handoff got %b exp 0", bus.st_ready); end
    checks++; if (pkt_end !== 32'd64) begin errors++; $display("FAIL full_pkt_end got %0d exp 64", pkt_end); end
    checks++; if (ts_seconds !== es || ts_nanoseconds !== ens) begin errors++; $display("FAIL full_ts got %h/%h exp %h/%h", ts_seconds, ts_nanoseconds, es, ens); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt - wb !== 16) begin errors++; $display("FAIL full_writes got %0d exp 16", wr_cnt - wb); end
    checks++; if (ctrl_cnt - cb !== 1) begin errors++; $display("FAIL full_ctrl_pulses got %0d exp 1", ctrl_cnt - cb); end
    checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL full_pkt_count got %0d exp 1", pkt_count); end
    checks++; if (wr_log[wb] !== 32'hA000_0000 || wr_log[wb+15] !== 32'hA000_000F) begin errors++; $display("FAIL full_data got %h..%h exp a0000000..a000000f", wr_log[wb], wr_log[wb+15]); end
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL full_ready_wait got %b exp 0", bus.st_ready); end
    finish_frame;
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b exp 1", bus.st_ready); end
  endtask

  task automatic test_partial_word;
    int wb;
    wb = wr_cnt;
    send_frame(16, 2'd3, 32'hB000_0000);
    checks++; if (pkt_end !== 32'd61) begin errors++; $display("FAIL partial_pkt_end got %0d exp 61", pkt_end); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt - wb !== 16) begin errors++; $display("FAIL partial_writes got %0d exp 16", wr_cnt - wb); end
    checks++; if (wr_log[wb+15] !== 32'hB000_000F) begin errors++; $display("FAIL partial_last_word got %h exp b000000f", wr_log[wb+15]); end
    checks++; if (pkt_count !== 16'd2) begin errors++; $display("FAIL partial_pkt_count got %0d exp 2", pkt_count); end
    finish_frame;
  endtask

  task automatic test_snaplen;
    int wb;
    snaplen = 16'd32; stall_seen = 1'b0; wb = wr_cnt;
    send_frame(25, 2'd0, 32'hC000_0000);
    checks++; if (pkt_end !== 32'd32) begin errors++; $display("FAIL snap_pkt_end got %0d exp 32", pkt_end); end
    checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL snap_ready_stall got %b exp 0", stall_seen); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt - wb !== 8) begin errors++; $display("FAIL snap_writes got %0d exp 8", wr_cnt - wb); end
    checks++; if (wr_log[wb+7] !== 32'hC000_0007) begin errors++; $display("FAIL snap_last_word got %h exp c0000007", wr_log[wb+7]); end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL snap_pkt_count got %0d exp 3", pkt_count); end
    finish_frame;
  endtask

  task automatic test_drop;
    int wb, cb;
    snaplen = 16'd1024; usedw = 9'd300; wb = wr_cnt; cb = ctrl_cnt;
    send_frame(10, 2'd0, 32'hD000_0000);
    repeat (3) @(posedge clk); #1;
    checks++; if (wr_cnt - wb !== 0) begin errors++; $display("FAIL drop_writes got %0d exp 0", wr_cnt - wb); end
    checks++; if (ctrl_cnt - cb !== 0) begin errors++; $display("FAIL drop_ctrl_pulses got %0d exp 0", ctrl_cnt - cb); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", drop_count); end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL drop_pkt_count got %0d exp 3", pkt_count); end
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b exp 1", bus.st_ready); end
    usedw = 9'd0; wb = wr_cnt;
    send_frame(4, 2'd0, 32'hE000_0000);
    checks++; if (wr_ctrl !== 1'b1 || pkt_end !== 32'd16) begin errors++; $display("FAIL drop_next_handoff got %b/%0d exp 1/16", wr_ctrl, pkt_end); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt - wb !== 4 || pkt_count !== 16'd4) begin errors++; $display("FAIL drop_next_capture got %0d/%0d exp 4/4", wr_cnt - wb, pkt_count); end
    finish_frame;
    snaplen = 16'd0;
  endtask

  task automatic test_proto_err;
    int wb;
    seconds = 32'h0000_2000; wb = wr_cnt;
    for (int i = 0; i < 5; i++) send_beat(32'hF000_0000 + 32'(i), i == 0, 1'b0, 2'd0);
    seconds = 32'h0000_3000;
    bus.st_data = 32'h1234_0000; bus.st_sop = 1'b1; bus.st_eop = 1'b0; bus.st_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL proto_sop_ready got %b exp 0", bus.st_ready); end
    @(posedge clk); #1;
    checks++; if (wr_ctrl !== 1'b1 || proto_err !== 1'b1) begin errors++; $display("FAIL proto_close got wr_ctrl %b proto_err %b exp 1/1", wr_ctrl, proto_err); end
    checks++; if (pkt_end !== 32'd20) begin errors++; $display("FAIL proto_pkt_end got %0d exp 20", pkt_end); end
    checks++; if (ts_seconds !== 32'h0000_2000) begin errors++; $display("FAIL proto_ts_held got %h exp 00002000", ts_seconds); end
    @(posedge clk); #1;
    checks++; if (bus.st_ready !== 1'b0 || pkt_count !== 16'd5) begin errors++; $display("FAIL proto_wait got ready %b count %0d exp 0/5", bus.st_ready, pkt_count); end
    wr_ctrl_rdy = 1'b1;
    @(posedge clk); #1; wr_ctrl_rdy = 1'b0;
    send_beat(32'h1234_0000, 1'b1, 1'b0, 2'd0);
    seconds = 32'h0000_3001;
    for (int i = 1; i < 4; i++) send_beat(32'h1234_0000 + 32'(i), 1'b0, i == 3, 2'd0);
    checks++; if (pkt_end !== 32'd16 || ts_seconds !== 32'h0000_3000) begin errors++; $display("FAIL proto_refr got len %0d ts %h exp 16/00003000", pkt_end, ts_seconds); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt - wb !== 9 || wr_log[wb+5] !== 32'h1234_0000) begin errors++; $display("FAIL proto_writes got %0d first %h exp 9/12340000", wr_cnt - wb, wr_log[wb+5]); end
    checks++; if (pkt_count !== 16'd6 || proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got count %0d err %b exp 6/1", pkt_count, proto_err); end
    finish_frame;
  endtask

  task automatic test_back_to_back;
    int wb;
    send_frame(4, 2'd0, 32'h5500_0000);
    seconds = 32'h0000_4000;
    bus.st_data = 32'h6600_0000; bus.st_sop = 1'b1; bus.st_eop = 1'b0; bus.st_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold cycle %0d got %b exp 0", k, bus.st_ready); end
    end
    @(posedge clk); #1; wr_ctrl_rdy = 1'b1;
    @(negedge clk);
    checks++; if (bus.st_ready !== 1'b0) begin errors++; $display("FAIL b2b_rdy_cycle got %b exp 0", bus.st_ready); end
    @(posedge clk); #1; wr_ctrl_rdy = 1'b0;
    checks++; if (bus.st_ready !== 1'b1) begin errors++; $display("FAIL b2b_release got %b exp 1", bus.st_ready); end
    wb = wr_cnt;
    send_beat(32'h6600_0000, 1'b1, 1'b0, 2'd0);
    seconds = 32'h0000_4001;
    send_beat(32'h6600_0001, 1'b0, 1'b0, 2'd0);
    send_beat(32'h6600_0002, 1'b0, 1'b1, 2'd0);
    checks++; if (pkt_end !== 32'd12 || ts_seconds !== 32'h0000_4000) begin errors++; $display("FAIL b2b_second got len %0d ts %h exp 12/00004000", pkt_end, ts_seconds); end
    repeat (2) @(posedge clk); #1;
    checks++; if (wr_cnt - wb !== 3 || wr_log[wb] !== 32'h6600_0000 || pkt_count !== 16'd8) begin errors++; $display("FAIL b2b_writes got %0d first %h count %0d exp 3/66000000/8", wr_cnt - wb, wr_log[wb], pkt_count); end
    finish_frame;
  endtask

  task automatic test_reset_mid_frame;
    int cb;
    for (int i = 0; i < 3; i++) send_beat(32'h7700_0000 + 32'(i), i == 0, 1'b0, 2'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.st_ready !== 1'b0 || fifo_wr !== 1'b0 || wr_ctrl !== 1'b0) begin errors++; $display("FAIL midrst_ctl got ready %b wr %b ctrl %b exp 0/0/0", bus.st_ready, fifo_wr, wr_ctrl); end
    checks++; if (pkt_end !== 32'd0 || ts_seconds !== 32'd0 || ts_nanoseconds !== 32'd0) begin errors++; $display("FAIL midrst_regs got %0d %h %h exp 0", pkt_end, ts_seconds, ts_nanoseconds); end
    checks++; if (pkt_count !== 16'd0 || drop_count !== 16'd0 || proto_err !== 1'b0) begin errors++; $display("FAIL midrst_stats got %0d/%0d/%b exp 0/0/0", pkt_count, drop_count, proto_err); end
    cb = ctrl_cnt;
    @(posedge clk); #1; reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (ctrl_cnt !== cb || bus.st_ready !== 1'b1) begin errors++; $display("FAIL midrst_no_handoff got pulses %0d ready %b exp %0d/1", ctrl_cnt - cb, bus.st_ready, 0); end
    send_frame(2, 2'd0, 32'h8800_0000);
    repeat (2) @(posedge clk); #1;
    checks++; if (pkt_end !== 32'd8 || pkt_count !== 16'd1) begin errors++; $display("FAIL midrst_recover got len %0d count %0d exp 8/1", pkt_end, pkt_count); end
    finish_frame;
  endtask

  initial begin
    bus.st_data = 32'd0; bus.st_valid = 1'b0; bus.st_sop = 1'b0;
    bus.st_eop = 1'b0; bus.st_empty = 2'd0;
    test_reset;
    test_full_frame;
    test_partial_word;
    test_snaplen;
    test_drop;
    test_proto_err;
    test_back_to_back;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
